// File: rtl/servile_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// servile_wb_rr_arbiter
//
// Shares one Wishbone classic memory port between NUM_MASTERS requesters
// (SERV ibus/dbus, debug loader, DMA, ...). Arbitration is round-robin and a
// grant is held for exactly one transaction. The slave-side request is
// registered, so a master strobe in cycle 0 produces a slave strobe in
// cycle 1. An optional watchdog terminates transactions the slave never
// acknowledges and returns ERR_DATA to the stalled master.
//
// Parameters
//   NUM_MASTERS  number of requesters, 2..8
//   TIMEOUT      cycles spent in ACTIVE before forced termination, 0 = off
//   ERR_DATA     read data returned on a timed-out transaction
//   MW           derived master index width, not meant to be overridden
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_wb_m_adr/dat     per-master address / write data, master k at [32k+:32]
//   i_wb_m_sel         per-master byte selects, master k at [4k+:4]
//   i_wb_m_we/stb      per-master write enable / request
//   o_wb_m_rdt         read data, broadcast to all masters (0 when no ack)
//   o_wb_m_ack         per-master acknowledge, at most one bit set
//   o_wb_s_*           registered slave request (adr, dat, sel, we, stb)
//   i_wb_s_rdt/ack     slave read data / acknowledge
//   o_grant            one-hot current owner, 0 when idle
//   o_err              sticky watchdog timeout flag
//   o_err_master       master index of the most recent timeout
//   i_err_clr          synchronous clear of o_err (a coincident timeout wins)
// -----------------------------------------------------------------------------
module servile_wb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = 0,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [32*NUM_MASTERS-1:0] i_wb_m_adr,
    input  logic [32*NUM_MASTERS-1:0] i_wb_m_dat,
    input  logic [4*NUM_MASTERS-1:0]  i_wb_m_sel,
    input  logic [NUM_MASTERS-1:0]    i_wb_m_we,
    input  logic [NUM_MASTERS-1:0]    i_wb_m_stb,
    output logic [31:0]               o_wb_m_rdt,
    output logic [NUM_MASTERS-1:0]    o_wb_m_ack,
    output logic [31:0]               o_wb_s_adr,
    output logic [31:0]               o_wb_s_dat,
    output logic [3:0]                o_wb_s_sel,
    output logic                      o_wb_s_we,
    output logic                      o_wb_s_stb,
    input  logic [31:0]               i_wb_s_rdt,
    input  logic                      i_wb_s_ack,
    output logic [NUM_MASTERS-1:0]    o_grant,
    output logic                      o_err,
    output logic [MW-1:0]             o_err_master,
    input  logic                      i_err_clr
);

    // Watchdog width; kept at 1 bit when the watchdog is disabled so the
    // counter never collapses to zero width.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t        state;
    logic [MW-1:0] ptr;          // last granted master; also the current owner in ACTIVE
    logic [CW-1:0] wdog;

    logic          found;
    logic [MW-1:0] winner;
    logic [MW-1:0] cand;
    logic [31:0]   win_adr;
    logic [31:0]   win_dat;
    logic [3:0]    win_sel;
    logic          win_we;
    logic          timeout_hit;
    logic          owner_stb;

    // Round-robin search starting just after the last owner. The last
    // candidate visited is ptr itself, so a lone requester is re-served.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = MW'((32'(ptr) + i) % NUM_MASTERS);
            if (!found && i_wb_m_stb[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Request fields of the winning master.
    always_comb begin
        win_adr = '0;
        win_dat = '0;
        win_sel = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (winner == MW'(k)) begin
                win_adr = i_wb_m_adr[32*k +: 32];
                win_dat = i_wb_m_dat[32*k +: 32];
                win_sel = i_wb_m_sel[4*k +: 4];
            end
        end
        win_we = i_wb_m_we[winner];
    end

    always_comb begin
        owner_stb   = i_wb_m_stb[ptr];
        timeout_hit = (TIMEOUT != 0) && (state == S_ACTIVE) &&
                      (wdog == CW'(TIMEOUT - 1));
    end

    // Master-side response is combinational so the owner sees the slave ack
    // in the same cycle. A real ack takes precedence over the watchdog.
    always_comb begin
        o_wb_m_ack = '0;
        o_wb_m_rdt = '0;
        if (state == S_ACTIVE) begin
            if (i_wb_s_ack) begin
                o_wb_m_ack = o_grant;
                o_wb_m_rdt = i_wb_s_rdt;
            end else if (timeout_hit) begin
                o_wb_m_ack = o_grant;
                o_wb_m_rdt = ERR_DATA;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            ptr          <= MW'(NUM_MASTERS - 1);
            wdog         <= '0;
            o_wb_s_adr   <= '0;
            o_wb_s_dat   <= '0;
            o_wb_s_sel   <= '0;
            o_wb_s_we    <= 1'b0;
            o_wb_s_stb   <= 1'b0;
            o_grant      <= '0;
            o_err        <= 1'b0;
            o_err_master <= '0;
        end else begin
            // Clear first so that a timeout later in this block overrides it.
            if (i_err_clr) begin
                o_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // Slave acks seen here belong to no transaction; ignored.
                    if (found) begin
                        o_wb_s_adr <= win_adr;
                        o_wb_s_dat <= win_dat;
                        o_wb_s_sel <= win_sel;
                        o_wb_s_we  <= win_we;
                        o_wb_s_stb <= 1'b1;
                        o_grant    <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
                        ptr        <= winner;
                        wdog       <= '0;
                        state      <= S_ACTIVE;
                    end
                end

                S_ACTIVE: begin
                    wdog <= wdog + 1'b1;
                    // Ack, timeout or owner abort all end the transaction the
                    // same way; only a timeout without ack records an error.
                    if (i_wb_s_ack || timeout_hit || !owner_stb) begin
                        o_wb_s_stb <= 1'b0;
                        o_grant    <= '0;
                        state      <= S_IDLE;
                    end
                    if (!i_wb_s_ack && timeout_hit) begin
                        o_err        <= 1'b1;
                        o_err_master <= ptr;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servile_wb_rr_arbiter.sv
module tb_servile_wb_rr_arbiter;

    typedef struct {
        int          m;
        logic [31:0] rdt;
    } exp_t;

    logic clk;
    logic rst_n;

    // DUT A: two masters, watchdog at 8 cycles
    logic [63:0]  a_m_adr, a_m_dat;
    logic [7:0]   a_m_sel;
    logic [1:0]   a_m_we, a_m_stb;
    logic [31:0]  a_m_rdt;
    logic [1:0]   a_m_ack;
    logic [31:0]  a_s_adr, a_s_dat;
    logic [3:0]   a_s_sel;
    logic         a_s_we, a_s_stb;
    logic [31:0]  a_s_rdt;
    logic         a_s_ack;
    logic [1:0]   a_grant;
    logic         a_err;
    logic [0:0]   a_err_master;
    logic         a_err_clr;

    // DUT B: four masters, watchdog off
    logic [127:0] b_m_adr, b_m_dat;
    logic [15:0]  b_m_sel;
    logic [3:0]   b_m_we, b_m_stb;
    logic [31:0]  b_m_rdt;
    logic [3:0]   b_m_ack;
    logic [31:0]  b_s_adr, b_s_dat;
    logic [3:0]   b_s_sel;
    logic         b_s_we, b_s_stb;
    logic [31:0]  b_s_rdt;
    logic         b_s_ack;
    logic [3:0]   b_grant;
    logic         b_err;
    logic [1:0]   b_err_master;
    logic         b_err_clr;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ptr_a;
    exp_t exp_q[$];
    exp_t exp_qb[$];

    servile_wb_rr_arbiter #(.NUM_MASTERS(2), .TIMEOUT(8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_m_adr(a_m_adr), .i_wb_m_dat(a_m_dat), .i_wb_m_sel(a_m_sel),
        .i_wb_m_we(a_m_we), .i_wb_m_stb(a_m_stb),
        .o_wb_m_rdt(a_m_rdt), .o_wb_m_ack(a_m_ack),
        .o_wb_s_adr(a_s_adr), .o_wb_s_dat(a_s_dat), .o_wb_s_sel(a_s_sel),
        .o_wb_s_we(a_s_we), .o_wb_s_stb(a_s_stb),
        .i_wb_s_rdt(a_s_rdt), .i_wb_s_ack(a_s_ack),
        .o_grant(a_grant), .o_err(a_err), .o_err_master(a_err_master),
        .i_err_clr(a_err_clr)
    );

    servile_wb_rr_arbiter #(.NUM_MASTERS(4), .TIMEOUT(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_m_adr(b_m_adr), .i_wb_m_dat(b_m_dat), .i_wb_m_sel(b_m_sel),
        .i_wb_m_we(b_m_we), .i_wb_m_stb(b_m_stb),
        .o_wb_m_rdt(b_m_rdt), .o_wb_m_ack(b_m_ack),
        .o_wb_s_adr(b_s_adr), .o_wb_s_dat(b_s_dat), .o_wb_s_sel(b_s_sel),
        .o_wb_s_we(b_s_we), .o_wb_s_stb(b_s_stb),
        .i_wb_s_rdt(b_s_rdt), .i_wb_s_ack(b_s_ack),
        .o_grant(b_grant), .o_err(b_err), .o_err_master(b_err_master),
        .i_err_clr(b_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round-robin choice: first requester after ptr, wrapping.
    function automatic int rr_pick(input int ptr, input logic [7:0] req, input int n);
        for (int i = 1; i <= n; i++) begin
            int k;
            k = (ptr + i) % n;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++; if ({a_s_stb, a_s_we, a_s_adr, a_s_dat, a_s_sel} !== '0) begin n_fail++; $display("FAIL reset_a_slave: got %h want 0", {a_s_stb, a_s_we, a_s_adr, a_s_dat, a_s_sel}); end
        n_checks++; if ({a_grant, a_m_ack, a_m_rdt, a_err, a_err_master} !== '0) begin n_fail++; $display("FAIL reset_a_master: got %h want 0", {a_grant, a_m_ack, a_m_rdt, a_err, a_err_master}); end
        n_checks++; if ({b_s_stb, b_grant, b_m_ack, b_m_rdt, b_err, b_err_master} !== '0) begin n_fail++; $display("FAIL reset_b: got %h want 0", {b_s_stb, b_grant, b_m_ack, b_m_rdt, b_err, b_err_master}); end
        // stray slave ack while idle must be ignored
        @(negedge clk);
        a_s_ack = 1'b1; a_s_rdt = 32'h5555_AAAA;
        #1;
        n_checks++; if (a_m_ack !== 2'b00) begin n_fail++; $display("FAIL idle_ack_ignored: got %b want 00", a_m_ack); end
        n_checks++; if (a_m_rdt !== 32'h0) begin n_fail++; $display("FAIL idle_rdt_zero: got %h want 0", a_m_rdt); end
        @(negedge clk);
        a_s_ack = 1'b0; a_s_rdt = '0;
        #1;
        n_checks++; if (a_s_stb !== 1'b0) begin n_fail++; $display("FAIL idle_ack_no_stb: got %b want 0", a_s_stb); end
    endtask

    task automatic test_single_read();
        exp_t e;
        @(negedge clk);
        a_m_adr[31:0] = 32'h0000_0100; a_m_we = 2'b00; a_m_stb = 2'b01;
        e.m = 0; e.rdt = 32'h1234_5678; exp_q.push_back(e);
        ptr_a = 0;
        #1;
        n_checks++; if (a_s_stb !== 1'b0) begin n_fail++; $display("FAIL t1_stb_c0: got %b want 0", a_s_stb); end
        @(negedge clk); #1;
        n_checks++; if (a_s_stb !== 1'b1) begin n_fail++; $display("FAIL t1_stb_c1: got %b want 1", a_s_stb); end
        n_checks++; if (a_grant !== 2'b01) begin n_fail++; $display("FAIL t1_grant: got %b want 01", a_grant); end
        n_checks++; if (a_s_adr !== 32'h0000_0100) begin n_fail++; $display("FAIL t1_s_adr: got %h want 00000100", a_s_adr); end
        @(negedge clk); #1;
        n_checks++; if (a_m_ack !== 2'b00) begin n_fail++; $display("FAIL t1_ack_c2: got %b want 00", a_m_ack); end
        @(negedge clk);
        a_s_ack = 1'b1; a_s_rdt = 32'h1234_5678;
        #1;
        if (a_m_ack !== 2'b00 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (a_m_ack !== (2'b01 << e.m)) begin n_fail++; $display("FAIL t1_ack: got %b want %b", a_m_ack, 2'b01 << e.m); end
            n_checks++; if (a_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t1_rdt: got %h want %h", a_m_rdt, e.rdt); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL t1_ack_missing: got %0d pending want 0", exp_q.size()); end
        @(negedge clk);
        a_s_ack = 1'b0; a_m_stb = 2'b00;
        #1;
        n_checks++; if ({a_s_stb, a_grant} !== 3'b000) begin n_fail++; $display("FAIL t1_idle_after: got %b want 000", {a_s_stb, a_grant}); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int age = 0, acks = 0, cyc = 0, last_cyc = -1, p;
        logic [1:0] prev_ack = 2'b00;
        p = ptr_a;
        for (int j = 0; j < 6; j++) begin
            p = rr_pick(p, 8'b11, 2);
            e.m = p; e.rdt = 32'hA000_0000 | 32'(j);
            exp_q.push_back(e);
        end
        ptr_a = p;
        @(negedge clk);
        a_m_adr = {32'h0000_0300, 32'h0000_0200}; a_m_we = 2'b00; a_m_stb = 2'b11;
        while (acks < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (a_s_stb) age++; else age = 0;
            a_s_ack = (age == 2);
            a_s_rdt = 32'hA000_0000 | 32'(acks);
            #1;
            if (a_m_ack !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL t2_unexpected_ack: got %b want none", a_m_ack);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (a_m_ack !== (2'b01 << e.m)) begin n_fail++; $display("FAIL t2_ack: got %b want %b", a_m_ack, 2'b01 << e.m); end
                    n_checks++; if (a_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t2_rdt: got %h want %h", a_m_rdt, e.rdt); end
                    n_checks++; if (a_s_adr !== (e.m == 1 ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL t2_s_adr: got %h want %h", a_s_adr, (e.m == 1 ? 32'h300 : 32'h200)); end
                end
                if (acks > 0) begin
                    n_checks++; if (a_m_ack === prev_ack) begin n_fail++; $display("FAIL t2_repeat_grant: got %b want not %b", a_m_ack, prev_ack); end
                end
                prev_ack = a_m_ack;
                acks++;
                last_cyc = cyc;
                if (acks == 6) a_m_stb = 2'b00;
            end
        end
        n_checks++; if (acks != 6) begin n_fail++; $display("FAIL t2_ack_count: got %0d want 6", acks); end
        n_checks++; if (last_cyc != 17) begin n_fail++; $display("FAIL t2_spacing: got last ack cycle %0d want 17", last_cyc); end
        exp_q.delete();
        @(negedge clk);
        a_s_ack = 1'b0;
        #1;
        n_checks++; if (a_s_stb !== 1'b0) begin n_fail++; $display("FAIL t2_idle_after: got %b want 0", a_s_stb); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int first_ack;
        // first timeout: master 1
        @(negedge clk);
        a_m_adr[63:32] = 32'h0000_0400; a_m_stb = 2'b10;
        e.m = 1; e.rdt = 32'hDEAD_BEEF; exp_q.push_back(e);
        ptr_a = 1;
        first_ack = -1;
        for (int cyc = 1; cyc <= 20 && first_ack < 0; cyc++) begin
            @(negedge clk); #1;
            if (a_m_ack !== 2'b00) begin
                first_ack = cyc;
                e = exp_q.pop_front();
                n_checks++; if (a_m_ack !== (2'b01 << e.m)) begin n_fail++; $display("FAIL t3_ack: got %b want %b", a_m_ack, 2'b01 << e.m); end
                n_checks++; if (a_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t3_rdt: got %h want %h", a_m_rdt, e.rdt); end
            end
        end
        n_checks++; if (first_ack != 8) begin n_fail++; $display("FAIL t3_ack_cycle: got %0d want 8", first_ack); end
        @(negedge clk);
        a_m_stb = 2'b00;
        #1;
        n_checks++; if ({a_err, a_err_master} !== 2'b11) begin n_fail++; $display("FAIL t3_err_set: got %b want 11", {a_err, a_err_master}); end
        n_checks++; if ({a_s_stb, a_grant} !== 3'b000) begin n_fail++; $display("FAIL t3_idle_after: got %b want 000", {a_s_stb, a_grant}); end
        @(negedge clk);
        a_err_clr = 1'b1;
        #1;
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL t3_err_sticky: got %b want 1", a_err); end
        @(negedge clk);
        a_err_clr = 1'b0;
        #1;
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL t3_err_clr: got %b want 0", a_err); end

        // second timeout: master 0, clear asserted in the timeout cycle
        @(negedge clk);
        a_m_adr[31:0] = 32'h0000_0410; a_m_stb = 2'b01;
        e.m = 0; e.rdt = 32'hDEAD_BEEF; exp_q.push_back(e);
        ptr_a = 0;
        first_ack = -1;
        for (int cyc = 1; cyc <= 20 && first_ack < 0; cyc++) begin
            @(negedge clk);
            a_err_clr = (cyc == 8);
            #1;
            if (a_m_ack !== 2'b00) begin
                first_ack = cyc;
                e = exp_q.pop_front();
                n_checks++; if (a_m_ack !== (2'b01 << e.m)) begin n_fail++; $display("FAIL t3b_ack: got %b want %b", a_m_ack, 2'b01 << e.m); end
                n_checks++; if (a_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t3b_rdt: got %h want %h", a_m_rdt, e.rdt); end
            end
        end
        n_checks++; if (first_ack != 8) begin n_fail++; $display("FAIL t3b_ack_cycle: got %0d want 8", first_ack); end
        @(negedge clk);
        a_err_clr = 1'b0; a_m_stb = 2'b00;
        #1;
        n_checks++; if ({a_err, a_err_master} !== 2'b10) begin n_fail++; $display("FAIL t3b_set_wins: got %b want 10", {a_err, a_err_master}); end
        @(negedge clk);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        a_m_adr[31:0] = 32'h0000_0500; a_m_stb = 2'b01;
        @(negedge clk);
        a_s_ack = 1'b1; a_s_rdt = 32'h0000_0077;
        #1;
        n_checks++; if (a_m_ack !== 2'b01) begin n_fail++; $display("FAIL t4_pre_ack: got %b want 01", a_m_ack); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({a_s_stb, a_grant, a_m_ack} !== 5'b0) begin n_fail++; $display("FAIL t4_async_clear: got %b want 00000", {a_s_stb, a_grant, a_m_ack}); end
        n_checks++; if (a_m_rdt !== 32'h0) begin n_fail++; $display("FAIL t4_async_rdt: got %h want 0", a_m_rdt); end
        @(negedge clk);
        rst_n = 1'b1; a_s_ack = 1'b0;
        a_m_adr = {32'h0000_0610, 32'h0000_0510}; a_m_stb = 2'b11;
        ptr_a = rr_pick(1, 8'b11, 2);
        e.m = ptr_a; e.rdt = 32'h0BAD_F00D; exp_q.push_back(e);
        @(negedge clk); #1;
        n_checks++; if (a_grant !== 2'b01) begin n_fail++; $display("FAIL t4_first_after_reset: got %b want 01", a_grant); end
        @(negedge clk);
        a_s_ack = 1'b1; a_s_rdt = 32'h0BAD_F00D;
        #1;
        if (a_m_ack !== 2'b00 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (a_m_ack !== (2'b01 << e.m)) begin n_fail++; $display("FAIL t4_ack: got %b want %b", a_m_ack, 2'b01 << e.m); end
            n_checks++; if (a_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t4_rdt: got %h want %h", a_m_rdt, e.rdt); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL t4_ack_missing: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        a_s_ack = 1'b0; a_m_stb = 2'b00;
    endtask

    task automatic test_abort();
        exp_t e;
        @(negedge clk);
        a_m_adr[31:0] = 32'h0000_0700; a_m_stb = 2'b01;
        @(negedge clk); #1;
        n_checks++; if (a_grant !== 2'b01) begin n_fail++; $display("FAIL t5_grant_m0: got %b want 01", a_grant); end
        @(negedge clk);
        a_m_stb = 2'b00;
        #1;
        n_checks++; if ({a_m_ack, a_s_stb} !== 3'b001) begin n_fail++; $display("FAIL t5_abort_no_ack: got %b want 001", {a_m_ack, a_s_stb}); end
        @(negedge clk);
        #1;
        n_checks++; if ({a_s_stb, a_grant} !== 3'b000) begin n_fail++; $display("FAIL t5_abort_idle: got %b want 000", {a_s_stb, a_grant}); end
        // late slave ack while idle, both masters now request
        a_s_ack = 1'b1; a_s_rdt = 32'hFFFF_0000;
        a_m_adr[63:32] = 32'h0000_0800; a_m_dat[63:32] = 32'hCAFE_F00D;
        a_m_sel[7:4] = 4'b0011; a_m_we = 2'b10; a_m_stb = 2'b11;
        e.m = 1; e.rdt = 32'h1357_9BDF; exp_q.push_back(e);
        ptr_a = 1;
        #1;
        n_checks++; if (a_m_ack !== 2'b00) begin n_fail++; $display("FAIL t5_late_ack: got %b want 00", a_m_ack); end
        @(negedge clk);
        a_s_ack = 1'b0;
        #1;
        n_checks++; if (a_grant !== 2'b10) begin n_fail++; $display("FAIL t5_grant_m1: got %b want 10", a_grant); end
        n_checks++; if ({a_s_adr, a_s_dat, a_s_sel, a_s_we} !== {32'h800, 32'hCAFE_F00D, 4'b0011, 1'b1}) begin n_fail++; $display("FAIL t5_s_write: got %h want %h", {a_s_adr, a_s_dat, a_s_sel, a_s_we}, {32'h800, 32'hCAFE_F00D, 4'b0011, 1'b1}); end
        @(negedge clk);
        a_s_ack = 1'b1; a_s_rdt = 32'h1357_9BDF;
        #1;
        if (a_m_ack !== 2'b00 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (a_m_ack !== (2'b01 << e.m)) begin n_fail++; $display("FAIL t5_ack: got %b want %b", a_m_ack, 2'b01 << e.m); end
            n_checks++; if (a_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t5_rdt: got %h want %h", a_m_rdt, e.rdt); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL t5_ack_missing: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        a_s_ack = 1'b0; a_m_stb = 2'b00; a_m_we = 2'b00;
    endtask

    task automatic test_rr_four();
        exp_t e;
        int age = 0, acks = 0, cyc = 0, p = 3;
        for (int j = 0; j < 4; j++) begin
            p = rr_pick(p, 8'b1010, 4);
            e.m = p; e.rdt = 32'hB000_0000 | 32'(j);
            exp_qb.push_back(e);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) b_m_adr[32*k +: 32] = 32'h1000 * (k + 1);
        b_m_stb = 4'b1010;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (b_s_stb) age++; else age = 0;
            b_s_ack = (age == 2);
            b_s_rdt = 32'hB000_0000 | 32'(acks);
            #1;
            if (b_m_ack !== 4'b0000) begin
                if (exp_qb.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL t6_unexpected_ack: got %b want none", b_m_ack);
                end else begin
                    e = exp_qb.pop_front();
                    n_checks++; if (b_m_ack !== (4'b0001 << e.m)) begin n_fail++; $display("FAIL t6_ack: got %b want %b", b_m_ack, 4'b0001 << e.m); end
                    n_checks++; if (b_m_rdt !== e.rdt) begin n_fail++; $display("FAIL t6_rdt: got %h want %h", b_m_rdt, e.rdt); end
                    n_checks++; if (b_s_adr !== 32'h1000 * (e.m + 1)) begin n_fail++; $display("FAIL t6_s_adr: got %h want %h", b_s_adr, 32'h1000 * (e.m + 1)); end
                end
                acks++;
                if (acks == 4) b_m_stb = 4'b0000;
            end
        end
        n_checks++; if (acks != 4) begin n_fail++; $display("FAIL t6_ack_count: got %0d want 4", acks); end
        exp_qb.delete();
        @(negedge clk);
        b_s_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_m_adr = '0; a_m_dat = '0; a_m_sel = '0; a_m_we = '0; a_m_stb = '0;
        a_s_rdt = '0; a_s_ack = 1'b0; a_err_clr = 1'b0;
        b_m_adr = '0; b_m_dat = '0; b_m_sel = '0; b_m_we = '0; b_m_stb = '0;
        b_s_rdt = '0; b_s_ack = 1'b0; b_err_clr = 1'b0;
        ptr_a = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_abort();
        test_rr_four();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test want finish before 100000");
        $fatal(1, "simulation time limit");
    end

endmodule
